// File: rtl/fir_top.sv
// Decimating FIR low-pass filter for the FM audio L+R path.
// Input FIFO -> TAPS-deep shift register -> sequential MAC -> output FIFO.
// One result is produced per DECIMATION accepted input samples.
// Optional build macro FIR_SATURATE_EN: accumulator saturates instead of wrapping.

module fir_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full, r_empty;
  logic             w_push, w_pop;
  logic [AW:0]      w_count_next;

  assign w_push  = i_wr_en & ~r_full;
  assign w_pop   = i_rd_en & ~r_empty;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  // Show-ahead read: head word is visible while non-empty, zero otherwise.
  assign o_dout  = r_empty ? '0 : r_mem[r_rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CNT_ONE;
    else if (!w_push && w_pop)
      w_count_next = r_count - CNT_ONE;
  end

  // Storage array; contents need no reset since reads are gated by empty.
  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers, count and registered full/empty flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_FULL);
      r_empty <= (w_count_next == '0);
    end
  end
endmodule

module fir_top #(
  parameter int unsigned TAPS       = 32,
  parameter int unsigned DECIMATION = 8,
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic signed [DATA_SIZE-1:0] COEFFS [TAPS] = '{
    32'hfffffffd, 32'hfffffffa, 32'hfffffff4, 32'hffffffed,
    32'hffffffe5, 32'hffffffdf, 32'hffffffe2, 32'hfffffff3,
    32'h00000015, 32'h0000004e, 32'h0000009b, 32'h000000f9,
    32'h0000015d, 32'h000001be, 32'h0000020e, 32'h00000243,
    32'h00000243, 32'h0000020e, 32'h000001be, 32'h0000015d,
    32'h000000f9, 32'h0000009b, 32'h0000004e, 32'h00000015,
    32'hfffffff3, 32'hffffffe2, 32'hffffffdf, 32'hffffffe5,
    32'hffffffed, 32'hfffffff4, 32'hfffffffa, 32'hfffffffd
  }
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 x_in_full,
  input  logic                 x_in_wr_en,
  input  logic [DATA_SIZE-1:0] x_in_din,
  output logic                 y_out_empty,
  input  logic                 y_out_rd_en,
  output logic [DATA_SIZE-1:0] y_out_dout
);
  localparam int unsigned PW = 2 * DATA_SIZE;
  localparam int unsigned DW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int unsigned TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [DW-1:0] DEC_LAST = DW'(DECIMATION - 1);
  localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);
  localparam logic [DW-1:0] DEC_ONE  = DW'(1);
  localparam logic [TW-1:0] TAP_ONE  = TW'(1);
  localparam logic signed [PW-1:0] DQ_BIAS = PW'(1023);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MAC, S_WRITE} state_t;

  state_t r_state, w_state_next;

  logic signed [DATA_SIZE-1:0] r_sr [TAPS];
  logic signed [DATA_SIZE-1:0] r_acc;
  logic [DW-1:0]               r_dec_cnt;
  logic [TW-1:0]               r_tap;

  logic [DATA_SIZE-1:0]        w_in_dout;
  logic                        w_in_empty, w_in_pop;
  logic                        w_out_full, w_out_push;
  logic                        w_mac_en;

  logic signed [DATA_SIZE-1:0] w_coef, w_sample, w_dq, w_acc_next;
  logic signed [PW-1:0]        w_prod, w_prod_bias, w_prod_q;

  fir_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_wr_en (x_in_wr_en),
    .i_din   (x_in_din),
    .o_full  (x_in_full),
    .i_rd_en (w_in_pop),
    .o_dout  (w_in_dout),
    .o_empty (w_in_empty)
  );

  fir_fifo #(.WIDTH(DATA_SIZE), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_wr_en (w_out_push),
    .i_din   (r_acc),
    .o_full  (w_out_full),
    .i_rd_en (y_out_rd_en),
    .o_dout  (y_out_dout),
    .o_empty (y_out_empty)
  );

  // Tap product and divide-by-1024 rounding toward zero; acc update.
  always_comb begin
    w_coef      = COEFFS[r_tap];
    w_sample    = r_sr[r_tap];
    w_prod      = PW'(w_coef) * PW'(w_sample);
    w_prod_bias = w_prod + (w_prod[PW-1] ? DQ_BIAS : '0);
    w_prod_q    = w_prod_bias >>> 10;
    w_dq        = w_prod_q[DATA_SIZE-1:0];
`ifdef FIR_SATURATE_EN
    begin
      logic [DATA_SIZE:0] w_sum;
      w_sum = {r_acc[DATA_SIZE-1], r_acc} + {w_dq[DATA_SIZE-1], w_dq};
      if (w_sum[DATA_SIZE] != w_sum[DATA_SIZE-1])
        w_acc_next = w_sum[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                      : {1'b0, {(DATA_SIZE-1){1'b1}}};
      else
        w_acc_next = w_sum[DATA_SIZE-1:0];
    end
`else
    w_acc_next  = r_acc + w_dq;
`endif
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_in_pop     = 1'b0;
    w_mac_en     = 1'b0;
    w_out_push   = 1'b0;
    unique case (r_state)
      S_IDLE:  w_state_next = S_SHIFT;
      S_SHIFT: begin
        if (!w_in_empty) begin
          w_in_pop = 1'b1;
          if (r_dec_cnt == DEC_LAST) w_state_next = S_MAC;
        end
      end
      S_MAC: begin
        w_mac_en = 1'b1;
        if (r_tap == TAP_LAST) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        if (!w_out_full) begin
          w_out_push   = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Shift register, decimation/tap counters and accumulator.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < TAPS; i++) r_sr[i] <= '0;
      r_acc     <= '0;
      r_dec_cnt <= '0;
      r_tap     <= '0;
    end else begin
      if (w_in_pop) begin
        r_sr[0] <= w_in_dout;
        for (int unsigned i = 1; i < TAPS; i++) r_sr[i] <= r_sr[i-1];
        r_dec_cnt <= (r_dec_cnt == DEC_LAST) ? '0 : r_dec_cnt + DEC_ONE;
      end
      if (w_mac_en) begin
        r_acc <= w_acc_next;
        r_tap <= (r_tap == TAP_LAST) ? '0 : r_tap + TAP_ONE;
      end
      if (w_out_push) r_acc <= '0;
    end
  end
endmodule

// File: tb/tb_fir_top.sv
// Bench for fir_top: fixed vectors, randomized streams checked against a
// direct-form reference computed from the coefficient table.
module tb_fir_top;
  logic        clock = 1'b0;
  logic        reset;
  logic        x_in_full;
  logic        x_in_wr_en;
  logic [31:0] x_in_din;
  logic        y_out_empty;
  logic        y_out_rd_en;
  logic [31:0] y_out_dout;

  int checks = 0;
  int errors = 0;
  int tx_q[$];
  int rx_q[$];
  int exp_q[$];
  bit rd_ready;

  int half_c [16] = '{
    32'hfffffffd, 32'hfffffffa, 32'hfffffff4, 32'hffffffed,
    32'hffffffe5, 32'hffffffdf, 32'hffffffe2, 32'hfffffff3,
    32'h00000015, 32'h0000004e, 32'h0000009b, 32'h000000f9,
    32'h0000015d, 32'h000001be, 32'h0000020e, 32'h00000243};

  fir_top dut (
    .clock       (clock),
    .reset       (reset),
    .x_in_full   (x_in_full),
    .x_in_wr_en  (x_in_wr_en),
    .x_in_din    (x_in_din),
    .y_out_empty (y_out_empty),
    .y_out_rd_en (y_out_rd_en),
    .y_out_dout  (y_out_dout)
  );

  always #5 clock = ~clock;

  function automatic int coef(input int j);
    return (j < 16) ? half_c[j] : half_c[31 - j];
  endfunction

  // y[k] = sum_j trunc0(c[j]*x[8k+7-j] / 1024), zero pre-history, 32-bit wrap.
  function automatic void build_model();
    exp_q.delete();
    for (int k = 0; k < tx_q.size() / 8; k++) begin
      int acc = 0;
      for (int j = 0; j < 32; j++) begin
        int idx = 8 * k + 7 - j;
        if (idx >= 0) acc += int'((longint'(coef(j)) * longint'(tx_q[idx])) / 1024);
      end
      exp_q.push_back(acc);
    end
  endfunction

  task automatic do_reset();
    x_in_wr_en  = 1'b0;
    x_in_din    = '0;
    y_out_rd_en = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Write every queued sample; strobes junk while full to prove it is ignored.
  task automatic drive_inputs(input int budget);
    int i = 0;
    int cyc = 0;
    while (i < tx_q.size() && cyc < budget) begin
      @(negedge clock);
      cyc++;
      x_in_wr_en = 1'b1;
      if (!x_in_full) begin
        x_in_din = tx_q[i];
        i++;
      end else begin
        x_in_din = 32'h7eadbeef;
      end
    end
    @(negedge clock);
    x_in_wr_en = 1'b0;
    checks++;
    if (i != tx_q.size()) begin
      errors++;
      $display("FAIL drive_timeout: wrote %0d required %0d", i, tx_q.size());
    end
  endtask

  task automatic collect(input int n, input int budget);
    int cyc = 0;
    while (rx_q.size() < n && cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (rd_ready && !y_out_empty) begin
        rx_q.push_back(int'(y_out_dout));
        y_out_rd_en = 1'b1;
      end else begin
        y_out_rd_en = 1'b0;
      end
    end
    @(negedge clock);
    y_out_rd_en = 1'b0;
  endtask

  task automatic run_free(input int n_out, input int budget);
    rx_q.delete();
    rd_ready = 1'b1;
    fork
      drive_inputs(budget);
      collect(n_out, budget);
    join
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (x_in_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", x_in_full); end
    checks++;
    if (y_out_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", y_out_empty); end
    checks++;
    if (y_out_dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", y_out_dout); end
  endtask

  task automatic test_impulse(input string tag);
    int want [5] = '{32'hfffffff3, 32'h00000243, 32'h00000015, 32'hfffffffd, 32'h00000000};
    do_reset();
    tx_q.delete();
    tx_q.push_back(32'h400);
    repeat (39) tx_q.push_back(0);
    run_free(5, 2000);
    checks++;
    if (rx_q.size() != 5) begin errors++; $display("FAIL %s_count: got %0d want 5", tag, rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== want[i]) begin
        errors++;
        $display("FAIL %s_y%0d: got %h want %h", tag, i, rx_q[i], want[i]);
      end
    end
  endtask

  task automatic test_dc();
    int want [6] = '{32'hffffff71, 32'h000008d4, 32'h00001237, 32'h000011a8, 32'h000011a8, 32'h000011a8};
    do_reset();
    tx_q.delete();
    repeat (48) tx_q.push_back(32'h400);
    run_free(6, 2000);
    checks++;
    if (rx_q.size() != 6) begin errors++; $display("FAIL dc_count: got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== want[i]) begin
        errors++;
        $display("FAIL dc_y%0d: got %h want %h", i, rx_q[i], want[i]);
      end
    end
  endtask

  task automatic test_rounding();
    do_reset();
    tx_q.delete();
    tx_q.push_back(1);
    repeat (31) tx_q.push_back(0);
    run_free(4, 2000);
    checks++;
    if (rx_q.size() != 4) begin errors++; $display("FAIL round_count: got %0d want 4", rx_q.size()); end
    for (int i = 0; i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== 0) begin
        errors++;
        $display("FAIL round_y%0d: got %h want 00000000", i, rx_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tx_q.delete();
    for (int i = 0; i < 400; i++)
      tx_q.push_back(int'($urandom_range(0, 2097152)) - 1048576);
    build_model();
    rx_q.delete();
    rd_ready = 1'b0;
    fork
      drive_inputs(20000);
      collect(50, 20000);
      begin
        repeat (1500) @(negedge clock);
        checks++;
        if (x_in_full !== 1'b1) begin errors++; $display("FAIL bp_full: got %b want 1", x_in_full); end
        checks++;
        if (y_out_empty !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", y_out_empty); end
        rd_ready = 1'b1;
      end
    join
    checks++;
    if (rx_q.size() != 50) begin errors++; $display("FAIL bp_count: got %0d want 50", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_y%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    tx_q.delete();
    for (int i = 0; i < 13; i++) tx_q.push_back(int'($urandom_range(1, 65535)));
    rd_ready = 1'b0;
    drive_inputs(500);
    repeat (60) @(negedge clock);
    checks++;
    if (y_out_empty !== 1'b0) begin errors++; $display("FAIL mid_pre_empty: got %b want 0", y_out_empty); end
    reset = 1'b0;
    #1;
    checks++;
    if (y_out_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b want 1", y_out_empty); end
    checks++;
    if (x_in_full !== 1'b0) begin errors++; $display("FAIL mid_full: got %b want 0", x_in_full); end
    test_impulse("mid_impulse");
  endtask

  task automatic test_stream();
    do_reset();
    tx_q.delete();
    for (int i = 0; i < 1000; i++)
      tx_q.push_back(int'($urandom_range(0, 2097152)) - 1048576);
    build_model();
    run_free(125, 20000);
    checks++;
    if (rx_q.size() != 125) begin errors++; $display("FAIL stream_count: got %0d want 125", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stream_y%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
    repeat (100) @(negedge clock);
    checks++;
    if (y_out_empty !== 1'b1) begin errors++; $display("FAIL stream_extra: empty got %b want 1", y_out_empty); end
  endtask

  initial begin
    rd_ready = 1'b0;
    test_reset();
    test_impulse("impulse");
    test_dc();
    test_rounding();
    test_backpressure();
    test_reset_midrun();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
